discriminator_seq: RTL

//   Parametrised, time-multiplexed successor to the fixed 9-3-1 discriminator MLP.
//   - One shared signed MAC evaluates an N_INPUT -> N_HIDDEN (ReLU) -> 1 (linear) network.
//   - Fixed-point datapath with valid/ready handshakes on both input and output.
//   - Sits between the feature front-end and the GAN loss/score logic.

---
 rtl/discriminator_seq_if.sv | 32 +++
 rtl/discriminator_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/discriminator_seq_if.sv
// Handshake and parameter bus for discriminator_seq.
// master: the feature front-end / consumer side; slave: the discriminator.
// Carries the input handshake (in_valid/in_ready + a_vec), the live-sampled
// weights and biases, the output handshake (out_valid/out_ready + y), and a
// debug copy of the FSM state.
interface discriminator_seq_if #(
  parameter int WIDTH    = 32,
  parameter int N_INPUT  = 9,
  parameter int N_HIDDEN = 3
) ();
  logic                                in_valid;
  logic                                in_ready;
  logic [N_INPUT*WIDTH-1:0]            a_vec;
  logic [N_INPUT*N_HIDDEN*WIDTH-1:0]   w_L2;
  logic [N_HIDDEN*WIDTH-1:0]           b_L2;
  logic [N_HIDDEN*WIDTH-1:0]           w_L3;
  logic [WIDTH-1:0]                    b_L3;
  logic                                out_valid;
  logic                                out_ready;
  logic [WIDTH-1:0]                    y;
  logic [2:0]                          state_dbg;

  modport master (
    output in_valid, a_vec, w_L2, b_L2, w_L3, b_L3, out_ready,
    input  in_ready, out_valid, y, state_dbg
  );

  modport slave (
    input  in_valid, a_vec, w_L2, b_L2, w_L3, b_L3, out_ready,
    output in_ready, out_valid, y, state_dbg
  );
endinterface

// File: rtl/discriminator_seq.sv
// discriminator_seq: time-multiplexed N_INPUT -> N_HIDDEN (ReLU) -> 1 (linear)
// fixed-point MLP built around one shared signed multiply-accumulate.
// Optional feature macro: DISC_SAT_EN (saturating narrowing instead of wrap).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE; out_valid is high only in
// DONE, and y is held constant there until out_valid & out_ready.
module discriminator_seq #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int N_INPUT  = 9,
  parameter int N_HIDDEN = 3
) (
  input logic                clk,
  input logic                rst,
  discriminator_seq_if.slave bus
);
  localparam int NMAX  = (N_INPUT > N_HIDDEN) ? N_INPUT : N_HIDDEN;
  localparam int ACC_W = 2*WIDTH + $clog2(NMAX) + 1;
  localparam int JW    = (N_INPUT  > 1) ? $clog2(N_INPUT)  : 1;
  localparam int IW    = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    L2_MAC = 3'd1,
    L2_ACT = 3'd2,
    L3_MAC = 3'd3,
    L3_ACT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                  state, state_n;
  logic [JW-1:0]           j;
  logic [IW-1:0]           i;
  logic signed [ACC_W-1:0] acc;
  logic signed [WIDTH-1:0] a_reg [N_INPUT];
  logic signed [WIDTH-1:0] h     [N_HIDDEN];
  logic signed [WIDTH-1:0] y_reg;

  logic signed [WIDTH-1:0] w2 [N_HIDDEN][N_INPUT];
  logic signed [WIDTH-1:0] b2 [N_HIDDEN];
  logic signed [WIDTH-1:0] w3 [N_HIDDEN];

  logic signed [WIDTH-1:0]   mul_a, mul_b, bias, nar;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   sum;
  logic                      last_j, last_i;

  // Unpack the flat weight/bias buses into indexable arrays.
  for (genvar gi = 0; gi < N_HIDDEN; gi++) begin : g_hid
    assign b2[gi] = bus.b_L2[gi*WIDTH +: WIDTH];
    assign w3[gi] = bus.w_L3[gi*WIDTH +: WIDTH];
    for (genvar gj = 0; gj < N_INPUT; gj++) begin : g_in
      assign w2[gi][gj] = bus.w_L2[(gi*N_INPUT+gj)*WIDTH +: WIDTH];
    end
  end

`ifdef DISC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

  // Drop FRAC fraction bits (floor), then clamp or wrap into WIDTH bits.
  function automatic logic signed [WIDTH-1:0] narrow(input logic signed [ACC_W-1:0] x);
`ifdef DISC_SAT_EN
    logic signed [ACC_W-1:0] s;
    s = x >>> FRAC;
    if (s > SAT_HI)      narrow = {1'b0, {(WIDTH-1){1'b1}}};
    else if (s < SAT_LO) narrow = {1'b1, {(WIDTH-1){1'b0}}};
    else                 narrow = WIDTH'(s);
`else
    narrow = WIDTH'(x >>> FRAC);
`endif
  endfunction

  assign last_j = (j == JW'(N_INPUT - 1));
  assign last_i = (i == IW'(N_HIDDEN - 1));

  // Route the shared multiplier: inputs x hidden weights, then hidden x output weights.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state == L2_MAC) begin
      mul_a = a_reg[j];
      mul_b = w2[i][j];
    end else if (state == L3_MAC) begin
      mul_a = h[i];
      mul_b = w3[i];
    end
  end

  assign prod = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);

  // Bias for the current activation step, aligned to the product scale.
  always_comb begin
    bias = (state == L3_ACT) ? bus.b_L3 : b2[i];
  end

  assign sum = acc + (ACC_W'(bias) <<< FRAC);
  assign nar = narrow(sum);

  // State register; reset aborts any sample in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_n = L2_MAC;
      end
      L2_MAC: if (last_j) state_n = L2_ACT;
      L2_ACT: state_n = last_i ? L3_MAC : L2_MAC;
      L3_MAC: if (last_i) state_n = L3_ACT;
      L3_ACT: state_n = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: capture sample, accumulate, activate, produce score.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      i     <= '0;
      j     <= '0;
      y_reg <= '0;
      for (int k = 0; k < N_INPUT; k++)  a_reg[k] <= '0;
      for (int k = 0; k < N_HIDDEN; k++) h[k]     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int k = 0; k < N_INPUT; k++) a_reg[k] <= bus.a_vec[k*WIDTH +: WIDTH];
            acc <= '0;
            i   <= '0;
            j   <= '0;
          end
        end
        L2_MAC: begin
          acc <= acc + ACC_W'(prod);
          j   <= last_j ? '0 : j + 1'b1;
        end
        L2_ACT: begin
          h[i] <= nar[WIDTH-1] ? '0 : nar;
          acc  <= '0;
          i    <= last_i ? '0 : i + 1'b1;
        end
        L3_MAC: begin
          acc <= acc + ACC_W'(prod);
          i   <= last_i ? '0 : i + 1'b1;
        end
        L3_ACT: begin
          y_reg <= nar;
          acc   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.y         = y_reg;
  assign bus.state_dbg = state;
endmodule
